// File: rtl/mem_io_responder.sv
// mem_io_responder
//   Byte-wide memory/IO target for a simple CPU-style initiator.
//   RAM region (mem_a[17:16] != 2'b11): 2^RAM_ADDR_BITS bytes, 1-cycle read latency.
//   IO region  (mem_a[17:16] == 2'b11), decoded on mem_a[2:0]:
//     0x30000 wr : push nonzero byte to TX queue (0x00 ignored)
//     0x30000 rd : received UART byte (RX path only when MEM_IO_RX_EN is defined)
//     0x30004 wr : set sticky program_stop, push 0x00 to TX queue
//     0x30004 rd : latch cycle counter into snapshot, return byte 0
//     0x30005-7  : snapshot bytes 1..3
//   Optional feature macro: MEM_IO_RX_EN (RX path). Without it, reads of 0x30000 return 0x00.
//
// Ports
//   clk_in, rst_in (async, active-low), rdy_in (bus enable)
//   mem_a, mem_wr, mem_dout -> access request; mem_din <- registered read data
//   tx_data/tx_valid/tx_ready : TX queue head toward UART; io_buffer_full = nearly full
//   rx_data/rx_valid/rx_ready : UART RX byte and one-cycle consume pulse
//   program_stop              : sticky stop flag
module mem_io_responder #(
  parameter int RAM_ADDR_BITS = 17,
  parameter int TX_FIFO_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        program_stop
);

  localparam int PW = $clog2(TX_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(TX_FIFO_DEPTH);
  localparam logic [CW-1:0] NEARLY_C = CW'(TX_FIFO_DEPTH - 1);

  logic [7:0] ram [0:(2**RAM_ADDR_BITS)-1];
  logic [RAM_ADDR_BITS-1:0] ram_addr;

  logic       is_io, ram_wr, ram_rd, io_wr, io_rd;
  logic [2:0] io_sel;

  logic [31:0] cycle_cnt, snapshot;
  logic [7:0]  rd_next;
  logic        snap_load, rx_take;

  logic [7:0]    fifo_mem [0:TX_FIFO_DEPTH-1];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic          push, push_ok, pop, stop_set;
  logic [7:0]    push_data;

  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_a[31:18];

  assign ram_addr = mem_a[RAM_ADDR_BITS-1:0];
  assign is_io    = (mem_a[17:16] == 2'b11);
  assign io_sel   = mem_a[2:0];
  assign ram_wr   = rdy_in & ~is_io & mem_wr;
  assign ram_rd   = rdy_in & ~is_io & ~mem_wr;
  // Once stopped, IO writes are dead; reads and RAM keep working.
  assign io_wr    = rdy_in & is_io & mem_wr & ~program_stop;
  assign io_rd    = rdy_in & is_io & ~mem_wr;

  // RAM array has no reset; contents survive rst_in.
  always_ff @(posedge clk_in) begin
    if (ram_wr) ram[ram_addr] <= mem_dout;
  end

  // IO write decode
  always_comb begin
    push      = 1'b0;
    push_data = 8'h00;
    stop_set  = 1'b0;
    if (io_wr) begin
      case (io_sel)
        3'd0: begin
          push      = (mem_dout != 8'h00);
          push_data = mem_dout;
        end
        3'd4: begin
          stop_set  = 1'b1;
          push      = 1'b1;
          push_data = 8'h00;
        end
        default: ;
      endcase
    end
  end

  // Read data mux; mem_din holds when no read is taken.
  always_comb begin
    rd_next   = mem_din;
    snap_load = 1'b0;
    rx_take   = 1'b0;
    if (ram_rd) begin
      rd_next = ram[ram_addr];
    end else if (io_rd) begin
      case (io_sel)
`ifdef MEM_IO_RX_EN
        3'd0: begin
          rd_next = rx_valid ? rx_data : 8'h00;
          rx_take = rx_valid;
        end
`endif
        3'd4: begin
          rd_next   = cycle_cnt[7:0];
          snap_load = 1'b1;
        end
        3'd5:    rd_next = snapshot[15:8];
        3'd6:    rd_next = snapshot[23:16];
        3'd7:    rd_next = snapshot[31:24];
        default: rd_next = 8'h00;
      endcase
    end
  end

`ifndef MEM_IO_RX_EN
  logic unused_rx;
  assign unused_rx = ^{rx_data, rx_valid};
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_din      <= 8'h00;
      rx_ready     <= 1'b0;
      cycle_cnt    <= 32'h0;
      snapshot     <= 32'h0;
      program_stop <= 1'b0;
    end else begin
      mem_din  <= rd_next;
      // rx_ready pulses alongside the returned byte, so it is low whenever rdy_in was low.
      rx_ready <= rx_take;
      if (rdy_in)    cycle_cnt    <= cycle_cnt + 32'd1;
      if (snap_load) snapshot     <= cycle_cnt;
      if (stop_set)  program_stop <= 1'b1;
    end
  end

  // TX queue; drains independently of rdy_in.
  assign tx_valid       = (fifo_cnt != '0);
  assign tx_data        = fifo_mem[rd_ptr];
  assign pop            = tx_valid & tx_ready;
  // A full queue still accepts a push when a pop frees a slot in the same cycle.
  assign push_ok        = push & ((fifo_cnt != DEPTH_C) | pop);
  assign io_buffer_full = (fifo_cnt >= NEARLY_C);

  always_ff @(posedge clk_in) begin
    if (push_ok) fifo_mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Testbench for mem_io_responder: directed accesses, expected read data and
// expected TX bytes are queued at issue time and checked by separate monitors.
module tb_mem_io_responder;

  logic        clk, rst_n, rdy;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout, mem_din, tx_data, rx_data;
  logic        io_buffer_full, tx_valid, tx_ready, rx_valid, rx_ready, program_stop;

  mem_io_responder #(.RAM_ADDR_BITS(17), .TX_FIFO_DEPTH(8)) dut (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy),
    .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din),
    .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .program_stop(program_stop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] rd_exp[$];
  logic [7:0] tx_exp[$];
  logic       chk_en;
  logic       rd_pend;
  logic [31:0] mcnt;
  int         rx_pulses;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference cycle count: advances on every enabled cycle out of reset.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) mcnt <= 32'h0;
    else if (rdy) mcnt <= mcnt + 32'd1;

  // Read-data monitor: a checked read presented at one negedge is due on mem_din at the next.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend = 1'b0;
    end else begin
      if (rd_pend) begin
        if (rd_exp.size() == 0) check("rd queue underflow", 1, 0);
        else check("mem_din", {24'h0, mem_din}, {24'h0, rd_exp.pop_front()});
      end
      rd_pend = rdy && chk_en;
    end
  end

  // TX monitor: every accepted byte must match the next expected byte.
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      if (tx_exp.size() == 0) check("tx unexpected byte", {24'h0, tx_data}, 32'hFFFF_FFFF);
      else check("tx_data", {24'h0, tx_data}, {24'h0, tx_exp.pop_front()});
    end
  end

  always @(negedge clk) if (rx_ready) rx_pulses++;

  task automatic idle();
    mem_a = 32'h30001; mem_wr = 1'b0; mem_dout = 8'h00; chk_en = 1'b0;
  endtask

  task automatic acc(input logic [31:0] a, input logic wr, input logic [7:0] d,
                     input logic chk, input logic [7:0] exp);
    mem_a = a; mem_wr = wr; mem_dout = d; chk_en = chk;
    if (chk) rd_exp.push_back(exp);
    @(posedge clk); #1;
    idle();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 40 && tx_exp.size() != 0; k++) @(posedge clk);
    #1;
    check("tx drain within budget", tx_exp.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] snap;
  initial begin
    rst_n = 1'b0; rdy = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    rx_pulses = 0;
    idle();
    #12;
    check("reset mem_din", mem_din, 0);
    check("reset tx_valid", tx_valid, 0);
    check("reset io_buffer_full", io_buffer_full, 0);
    check("reset rx_ready", rx_ready, 0);
    check("reset program_stop", program_stop, 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // RAM write then read, 1-cycle latency
    acc(32'h00123, 1, 8'hA5, 0, 0);
    acc(32'h00123, 0, 8'h00, 1, 8'hA5);
    acc(32'h1FFFF, 1, 8'h3C, 0, 0);
    acc(32'h1FFFF, 0, 8'h00, 1, 8'h3C);
    acc(32'h30002, 0, 8'h00, 1, 8'h00);   // undecoded IO reads zero

    // TX fill with sink stalled: nearly-full after 7, 8th kept, 9th dropped
    for (int i = 0; i < 9; i++) begin
      acc(32'h30000, 1, 8'h41 + 8'(i), 0, 0);
      if (i < 8) tx_exp.push_back(8'h41 + 8'(i));
      check($sformatf("io_buffer_full after push %0d", i + 1), io_buffer_full, (i >= 6) ? 1 : 0);
      check("tx head while stalled", tx_data, 8'h41);
    end
    tx_ready = 1'b1;
    wait_drain();
    cycles(2);
    check("tx_valid after drain", tx_valid, 0);
    check("io_buffer_full after drain", io_buffer_full, 0);

    // Reset mid-operation: queued bytes and in-flight read are discarded
    tx_ready = 1'b0;
    acc(32'h30000, 1, 8'h21, 0, 0);
    acc(32'h30000, 1, 8'h22, 0, 0);
    acc(32'h00123, 0, 8'h00, 0, 0);
    check("read before mid reset", mem_din, 8'hA5);
    rst_n = 1'b0; #1;
    check("mid reset mem_din", mem_din, 0);
    check("mid reset tx_valid", tx_valid, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    tx_ready = 1'b1;
    acc(32'h00123, 0, 8'h00, 1, 8'hA5);   // RAM survives reset
    cycles(2);

    // Zero byte ignored; stop write pushes 0x00; later IO writes ignored
    acc(32'h30000, 1, 8'h00, 0, 0);
    check("zero byte not pushed", tx_valid, 0);
    tx_exp.push_back(8'h00);
    acc(32'h30004, 1, 8'h77, 0, 0);
    check("program_stop set", program_stop, 1);
    check("stop pushes 0x00 valid", tx_valid, 1);
    check("stop pushes 0x00 data", tx_data, 8'h00);
    acc(32'h30000, 1, 8'h55, 0, 0);
    check("write after stop ignored", tx_valid, 0);
    cycles(3);
    check("program_stop sticky", program_stop, 1);
    acc(32'h00456, 1, 8'h6B, 0, 0);
    acc(32'h00456, 0, 8'h00, 1, 8'h6B);

    // Cycle counter and snapshot
    cycles(300);
    snap = mcnt;
    acc(32'h30004, 0, 8'h00, 1, snap[7:0]);
    acc(32'h30005, 0, 8'h00, 1, snap[15:8]);
    acc(32'h30006, 0, 8'h00, 1, snap[23:16]);
    acc(32'h30007, 0, 8'h00, 1, snap[31:24]);
    acc(32'h30005, 0, 8'h00, 1, snap[15:8]);   // snapshot unchanged by byte reads
    acc(32'h00123, 0, 8'h00, 1, 8'hA5);
    // Disabled bus: no write, mem_din/counter hold
    rdy = 1'b0; mem_a = 32'h00123; mem_wr = 1'b1; mem_dout = 8'hEE;
    cycles(10);
    check("mem_din hold while disabled", mem_din, 8'hA5);
    rdy = 1'b1; idle();
    acc(32'h00123, 0, 8'h00, 1, 8'hA5);
    snap = mcnt;
    acc(32'h30004, 0, 8'h00, 1, snap[7:0]);
    acc(32'h30005, 0, 8'h00, 1, snap[15:8]);

    // RX path
    rx_pulses = 0;
    rx_valid = 1'b1; rx_data = 8'h5A;
`ifdef MEM_IO_RX_EN
    acc(32'h30000, 0, 8'h00, 1, 8'h5A);
    check("rx_ready pulse", rx_ready, 1);
`else
    acc(32'h30000, 0, 8'h00, 1, 8'h00);
    check("rx_ready tied low", rx_ready, 0);
`endif
    cycles(3);
`ifdef MEM_IO_RX_EN
    check("rx_ready pulse count", rx_pulses, 1);
`else
    check("rx_ready pulse count", rx_pulses, 0);
`endif
    rx_valid = 1'b0;
    acc(32'h30000, 0, 8'h00, 1, 8'h00);
    cycles(3);

    check("rd queue empty at end", rd_exp.size(), 0);
    check("tx queue empty at end", tx_exp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
